// File: rtl/sha2_pkg.sv
// Shared SHA-2 schedule definitions: sigma rotate/shift amounts, sigma
// functions for 32- and 64-bit words, schedule length and FSM states.
package sha2_pkg;

   localparam int unsigned S0_32_A = 7;
   localparam int unsigned S0_32_B = 18;
   localparam int unsigned S0_32_C = 3;
   localparam int unsigned S1_32_A = 17;
   localparam int unsigned S1_32_B = 19;
   localparam int unsigned S1_32_C = 10;
   localparam int unsigned S0_64_A = 1;
   localparam int unsigned S0_64_B = 8;
   localparam int unsigned S0_64_C = 7;
   localparam int unsigned S1_64_A = 19;
   localparam int unsigned S1_64_B = 61;
   localparam int unsigned S1_64_C = 6;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   function automatic int unsigned r_f(input int unsigned n);
      return (n == 32) ? 64 : 80;
   endfunction

   // Words travel zero-extended in 64 bits; a 32-bit rotate wraps at bit 31.
   function automatic logic [63:0] rotr_f(input int unsigned n, input logic [63:0] x,
                                          input int unsigned s);
      logic [31:0] v;
      v = x[31:0];
      if (n == 32) return {32'd0, (v >> s) | (v << (32 - s))};
      return (x >> s) | (x << (64 - s));
   endfunction

   function automatic logic [63:0] sig0_f(input int unsigned n, input logic [63:0] x);
      if (n == 32)
         return rotr_f(n, x, S0_32_A) ^ rotr_f(n, x, S0_32_B) ^ (x >> S0_32_C);
      return rotr_f(n, x, S0_64_A) ^ rotr_f(n, x, S0_64_B) ^ (x >> S0_64_C);
   endfunction

   function automatic logic [63:0] sig1_f(input int unsigned n, input logic [63:0] x);
      if (n == 32)
         return rotr_f(n, x, S1_32_A) ^ rotr_f(n, x, S1_32_B) ^ (x >> S1_32_C);
      return rotr_f(n, x, S1_64_A) ^ rotr_f(n, x, S1_64_B) ^ (x >> S1_64_C);
   endfunction

endpackage

// File: rtl/sha_sched_word.sv
// Combinational next schedule word: Wn = sig1(w14) + w9 + sig0(w1) + w0 mod 2^N.
module sha_sched_word
   import sha2_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] w0,
   input  logic [N-1:0] w1,
   input  logic [N-1:0] w9,
   input  logic [N-1:0] w14,
   output logic [N-1:0] wn
);

   logic [63:0] s0;
   logic [63:0] s1;
   logic [63:0] sum;

   assign s0  = sig0_f(N, 64'(w1));
   assign s1  = sig1_f(N, 64'(w14));
   assign sum = s1 + 64'(w9) + s0 + 64'(w0);
   assign wn  = sum[N-1:0];

   // Carries above bit N-1 are discarded by design.
   if (N < 64) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^sum[63:N];
   end

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-2 message schedule: loads a 16-word block and streams W_0..W_{R-1}
// over valid/ready, computing each new word from a 16-entry sliding window.
module sha_msg_schedule
   import sha2_pkg::*;
#(
   parameter  int N  = 32,
   localparam int R  = r_f(N),
   localparam int TW = $clog2(R)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic [0:15][N-1:0]  m_i,
   input  logic                abort_i,
   output logic                ready_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [N-1:0]        w_o,
   output logic [TW-1:0]       t_o,
   output logic                last_o
);

   if (N != 32 && N != 64) begin : g_bad_n
      $error("sha_msg_schedule: N must be 32 or 64");
   end

   localparam logic [TW-1:0] T_LAST = TW'(R - 1);

   state_t         state;
   logic [N-1:0]   win [16];
   logic [TW-1:0]  t;
   logic [N-1:0]   wn;
   logic           ready_q;
   logic           valid_q;
   logic           last_q;

   sha_sched_word #(.N(N)) u_word (
      .w0  (win[0]),
      .w1  (win[1]),
      .w9  (win[9]),
      .w14 (win[14]),
      .wn  (wn)
   );

   // NOTE: every register here, including the window array, uses <= so all
   // updates read pre-edge values; the window is cleared on reset because
   // w_o is driven straight from win[0] and must read 0 after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         t       <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (load_i) begin
                  for (int i = 0; i < 16; i++) win[i] <= m_i[i];
                  t       <= '0;
                  state   <= S_RUN;
                  ready_q <= 1'b0;
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
               end
            end
            S_RUN: begin
               if (abort_i) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
               end else if (ready_i) begin
                  for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                  win[15] <= wn;
                  t       <= t + 1'b1;
                  if (t == T_LAST) begin
                     state   <= S_IDLE;
                     ready_q <= 1'b1;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                  end else begin
                     last_q  <= (t == T_LAST - 1'b1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ready_o = ready_q;
   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign w_o     = win[0];
   assign t_o     = t;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule at N=32 and N=64: "abc" streams,
// backpressure, ignored load, abort and mid-stream reset.
module tb_sha_msg_schedule;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic              load_a, abort_a, rdy_a;
   logic [0:15][31:0] m_a;
   logic              ready_a, valid_a, last_a;
   logic [31:0]       w_a;
   logic [5:0]        t_a;

   logic              load_b, abort_b, rdy_b;
   logic [0:15][63:0] m_b;
   logic              ready_b, valid_b, last_b;
   logic [63:0]       w_b;
   logic [6:0]        t_b;

   sha_msg_schedule #(.N(32)) dut_a (
      .clk_i(clk), .rst_i(rst), .load_i(load_a), .m_i(m_a), .abort_i(abort_a),
      .ready_o(ready_a), .valid_o(valid_a), .ready_i(rdy_a),
      .w_o(w_a), .t_o(t_a), .last_o(last_a)
   );

   sha_msg_schedule #(.N(64)) dut_b (
      .clk_i(clk), .rst_i(rst), .load_i(load_b), .m_i(m_b), .abort_i(abort_b),
      .ready_o(ready_b), .valid_o(valid_b), .ready_i(rdy_b),
      .w_o(w_b), .t_o(t_b), .last_o(last_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] abc32 [64];
   logic [31:0] alt32 [64];
   logic [31:0] obs32 [64];
   logic [31:0] base32[64];
   logic [63:0] abc64 [80];
   logic [63:0] obs64 [80];
   int          n_xfer, n_last;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Textbook schedule recurrence over the full W array, written with explicit bit rotations.
   function automatic logic [31:0] ss0_32(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ss1_32(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction
   function automatic logic [63:0] ss0_64(input logic [63:0] x);
      return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
   endfunction
   function automatic logic [63:0] ss1_64(input logic [63:0] x);
      return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
   endfunction

   task automatic load32(input bit alt);
      check("idle_ready", ready_a, 1'b1);
      for (int i = 0; i < 16; i++) m_a[i] = alt ? alt32[i] : abc32[i];
      load_a = 1'b1;
      step();
      load_a = 1'b0;
      check("load_valid", valid_a, 1'b1);
      check("load_w0", w_a, alt ? alt32[0] : abc32[0]);
   endtask

   // inj_kind: 0 none, 1 load pulse with other data, 2 abort, 3 reset; applied at word inj_t.
   task automatic run32(input bit alt, input bit bp, input int inj_t, input int inj_kind);
      logic [31:0] prev_w;
      logic [5:0]  prev_t;
      logic        prev_last;
      logic [31:0] exp_w;
      bit          rdy;
      bit          injected;
      int          idx, budget;
      idx = 0; budget = 0; injected = 0;
      n_xfer = 0; n_last = 0;
      while (idx < 64 && budget < 1000) begin
         budget++;
         if (!injected && inj_kind != 0 && idx == inj_t) begin
            injected = 1;
            if (inj_kind == 1) begin
               for (int i = 0; i < 16; i++) m_a[i] = alt32[i] ^ 32'hA5A5_0F0F;
               load_a = 1'b1;
            end else if (inj_kind == 2) begin
               abort_a = 1'b1;
               rdy_a   = 1'b1;
               step();
               abort_a = 1'b0;
               check("abort_valid", valid_a, 1'b0);
               check("abort_ready", ready_a, 1'b1);
               return;
            end else begin
               rst   = 1'b1;
               rdy_a = 1'b1;
               step();
               check("rst_valid", valid_a, 1'b0);
               check("rst_ready", ready_a, 1'b1);
               check("rst_w", w_a, 32'h0);
               check("rst_t", t_a, 6'd0);
               check("rst_last", last_a, 1'b0);
               rst = 1'b0;
               return;
            end
         end
         rdy = (bp && inj_kind != 1) ? bit'($urandom_range(0, 1)) : 1'b1;
         rdy_a = rdy;
         prev_w = w_a; prev_t = t_a; prev_last = last_a;
         check("run_valid", valid_a, 1'b1);
         if (!valid_a) begin
            load_a = 1'b0;
            break;
         end
         step();
         load_a = 1'b0;
         if (rdy) begin
            exp_w = alt ? alt32[idx] : abc32[idx];
            check("stream_w", prev_w, exp_w);
            check("stream_t", prev_t, 64'(idx));
            check("stream_last", prev_last, idx == 63);
            obs32[idx] = prev_w;
            n_xfer++;
            if (prev_last) n_last++;
            idx++;
         end else begin
            check("hold_w", w_a, prev_w);
            check("hold_t", t_a, prev_t);
         end
      end
      rdy_a = 1'b1;
      check("stream_count", 64'(idx), 64'd64);
      check("post_ready", ready_a, 1'b1);
      check("post_valid", valid_a, 1'b0);
   endtask

   function automatic int diff_vs_base();
      int d = 0;
      for (int i = 0; i < 64; i++) if (obs32[i] !== base32[i]) d++;
      return d;
   endfunction

   initial begin
      int idx, budget;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) begin
            abc32[t] = (t == 0) ? 32'h61626380 : (t == 15) ? 32'h00000018 : 32'h0;
            alt32[t] = 32'h01234567 + 32'(t) * 32'h1F2E3D4C;
         end else begin
            abc32[t] = ss1_32(abc32[t-2]) + abc32[t-7] + ss0_32(abc32[t-15]) + abc32[t-16];
            alt32[t] = ss1_32(alt32[t-2]) + alt32[t-7] + ss0_32(alt32[t-15]) + alt32[t-16];
         end
      end
      for (int t = 0; t < 80; t++) begin
         if (t < 16)
            abc64[t] = (t == 0) ? 64'h6162638000000000 : (t == 15) ? 64'h18 : 64'h0;
         else
            abc64[t] = ss1_64(abc64[t-2]) + abc64[t-7] + ss0_64(abc64[t-15]) + abc64[t-16];
      end

      rst = 1'b1;
      load_a = 1'b0; abort_a = 1'b0; rdy_a = 1'b1; m_a = '0;
      load_b = 1'b0; abort_b = 1'b0; rdy_b = 1'b1; m_b = '0;
      step(); step();
      rst = 1'b0;
      step();
      check("reset_ready_a", ready_a, 1'b1);
      check("reset_valid_a", valid_a, 1'b0);
      check("reset_w_a", w_a, 32'h0);
      check("reset_t_a", t_a, 6'd0);
      check("reset_last_a", last_a, 1'b0);
      check("reset_ready_b", ready_b, 1'b1);
      check("reset_valid_b", valid_b, 1'b0);
      check("reset_w_b", w_b, 64'h0);

      // "abc" with ready held high
      load32(1'b0);
      run32(1'b0, 1'b0, -1, 0);
      check("abc_xfers", 64'(n_xfer), 64'd64);
      check("abc_last_cnt", 64'(n_last), 64'd1);
      check("abc_w16", obs32[16], 32'h61626380);
      check("abc_w17", obs32[17], 32'h000F0000);
      for (int i = 0; i < 64; i++) base32[i] = obs32[i];

      // 50% backpressure
      load32(1'b0);
      run32(1'b0, 1'b1, -1, 0);
      check("bp_last_cnt", 64'(n_last), 64'd1);
      check("bp_vs_base", 64'(diff_vs_base()), 64'd0);

      // load pulsed mid-stream is ignored
      load32(1'b0);
      run32(1'b0, 1'b0, 5, 1);
      check("ldign_xfers", 64'(n_xfer), 64'd64);
      check("ldign_vs_base", 64'(diff_vs_base()), 64'd0);

      // abort at t=20, then an immediate new block
      load32(1'b0);
      run32(1'b0, 1'b0, 20, 2);
      check("abort_xfers", 64'(n_xfer), 64'd20);
      load32(1'b1);
      run32(1'b1, 1'b0, -1, 0);
      check("alt_xfers", 64'(n_xfer), 64'd64);

      // reset at t=30, then a fresh "abc" block
      load32(1'b0);
      run32(1'b0, 1'b0, 30, 3);
      load32(1'b0);
      run32(1'b0, 1'b0, -1, 0);
      check("rst_vs_base", 64'(diff_vs_base()), 64'd0);

      // N=64 "abc"
      check("idle_ready64", ready_b, 1'b1);
      for (int i = 0; i < 16; i++) m_b[i] = abc64[i];
      load_b = 1'b1;
      step();
      load_b = 1'b0;
      idx = 0; budget = 0; n_last = 0;
      while (valid_b && idx < 80 && budget < 200) begin
         budget++;
         check("stream64_w", w_b, abc64[idx]);
         check("stream64_t", t_b, 64'(idx));
         check("stream64_last", last_b, idx == 79);
         obs64[idx] = w_b;
         if (last_b) n_last++;
         idx++;
         step();
      end
      check("abc64_count", 64'(idx), 64'd80);
      check("abc64_last_cnt", 64'(n_last), 64'd1);
      check("abc64_w16", obs64[16], 64'h6162638000000000);
      check("abc64_w17", obs64[17], 64'h00030000000000C0);
      check("abc64_post_ready", ready_b, 1'b1);
      check("abc64_post_valid", valid_b, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
